// File: rtl/d_latch.sv
// Level-sensitive D latch with asynchronous active-low clear.
// Transparent while en=1, holds while en=0.
module d_latch #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic en,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_latch begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/d_ff_master_slave.sv
// Positive-edge D flip-flop built per bit from a master/slave latch pair,
// with asynchronous active-low reset applied to both latches.
module d_ff_master_slave #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  localparam logic RESET_VAL = 1'b0;

  logic             clk_n;
  logic [WIDTH-1:0] m;

  assign clk_n = ~clk;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      // Master follows D during the low phase; slave passes it on while high.
      d_latch #(.RST_VAL(RESET_VAL)) u_master (
        .en    (clk_n),
        .rst_n (rst_n),
        .d     (D[gi]),
        .q     (m[gi])
      );

      d_latch #(.RST_VAL(RESET_VAL)) u_slave (
        .en    (clk),
        .rst_n (rst_n),
        .d     (m[gi]),
        .q     (Q[gi])
      );
    end
  endgenerate

  assign Qn = ~Q;

endmodule

// File: tb/tb_d_ff_master_slave.sv
// Self-checking bench for d_ff_master_slave at WIDTH=1 and WIDTH=4,
// using a vector table plus hand-written reset and glitch sequences.
module tb_d_ff_master_slave;

  typedef struct {
    logic       d;
    logic [3:0] d4;
    logic       exp_q;
    logic [3:0] exp_q4;
  } vec_t;

  typedef struct {
    logic       q;
    logic [3:0] q4;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       d1;
  logic       q1;
  logic       qn1;
  logic [3:0] d4;
  logic [3:0] q4;
  logic [3:0] qn4;

  int   checks;
  int   errors;
  exp_t sb[$];
  vec_t vecs[9];
  logic       prev_q;
  logic [3:0] prev_q4;

  d_ff_master_slave #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (d1),
    .Q     (q1),
    .Qn    (qn1)
  );

  d_ff_master_slave #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (d4),
    .Q     (q4),
    .Qn    (qn4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 20000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic eq, input logic [3:0] eq4);
    chk({name, "_q1"},  {3'b000, q1},  {3'b000, eq});
    chk({name, "_qn1"}, {3'b000, qn1}, {3'b000, ~eq});
    chk({name, "_q4"},  q4,  eq4);
    chk({name, "_qn4"}, qn4, ~eq4);
  endtask

  task automatic push(input logic eq, input logic [3:0] eq4);
    exp_t e;
    e.q  = eq;
    e.q4 = eq4;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got Q=%b Q4=%b, expected an entry", name, q1, q4);
    end else begin
      e = sb.pop_front();
      $display("txn %s t=%0t: D=%b D4=%b -> Q=%b Qn=%b Q4=%b Qn4=%b (exp Q=%b Q4=%b)",
               name, $time, d1, d4, q1, qn1, q4, qn4, e.q, e.q4);
      check_all(name, e.q, e.q4);
      prev_q  = e.q;
      prev_q4 = e.q4;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{d: 1'b0, d4: 4'b0000, exp_q: 1'b0, exp_q4: 4'b0000};
    vecs[1] = '{d: 1'b0, d4: 4'b0011, exp_q: 1'b0, exp_q4: 4'b0011};
    vecs[2] = '{d: 1'b1, d4: 4'b1010, exp_q: 1'b1, exp_q4: 4'b1010};
    vecs[3] = '{d: 1'b1, d4: 4'b0101, exp_q: 1'b1, exp_q4: 4'b0101};
    vecs[4] = '{d: 1'b1, d4: 4'b1111, exp_q: 1'b1, exp_q4: 4'b1111};
    vecs[5] = '{d: 1'b0, d4: 4'b0000, exp_q: 1'b0, exp_q4: 4'b0000};
    vecs[6] = '{d: 1'b1, d4: 4'b1001, exp_q: 1'b1, exp_q4: 4'b1001};
    vecs[7] = '{d: 1'b0, d4: 4'b0110, exp_q: 1'b0, exp_q4: 4'b0110};
    vecs[8] = '{d: 1'b1, d4: 4'b1100, exp_q: 1'b1, exp_q4: 4'b1100};

    // Reset state, then release at t=2 during the first low phase.
    rst_n = 1'b0;
    d1    = 1'b0;
    d4    = 4'b0000;
    #1;
    check_all("reset_state", 1'b0, 4'b0000);
    #1;
    rst_n   = 1'b1;
    prev_q  = 1'b0;
    prev_q4 = 4'b0000;

    // Table: drive in low phase, confirm hold, capture on rise, hold over fall.
    for (int i = 0; i < 9; i++) begin
      d1 = vecs[i].d;
      d4 = vecs[i].d4;
      push(vecs[i].exp_q, vecs[i].exp_q4);
      #1;
      check_all("low_phase_hold", prev_q, prev_q4);
      @(posedge clk);
      #2;
      pop_check("capture");
      @(negedge clk);
      #1;
      check_all("falling_edge_hold", prev_q, prev_q4);
      #1;
    end

    // Glitch entirely inside the high phase must not reach Q.
    @(posedge clk);
    #1; d1 = 1'b0; d4 = 4'b0000;
    #1; d1 = 1'b1; d4 = 4'b1111;
    #1; d1 = 1'b0; d4 = 4'b0000;
    push(1'b0, 4'b0000);
    #1;
    check_all("glitch_hold", 1'b1, 4'b1100);
    @(posedge clk);
    #2;
    pop_check("glitch_capture");

    // Load a one, then assert reset mid-high-phase.
    @(negedge clk);
    #2; d1 = 1'b1; d4 = 4'b1010;
    push(1'b1, 4'b1010);
    @(posedge clk);
    #2;
    pop_check("pre_reset_capture");
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 4'b0000);
    repeat (2) begin
      @(posedge clk);
      #2;
      check_all("reset_dominates_edge", 1'b0, 4'b0000);
      @(negedge clk);
      #1;
      check_all("reset_low_phase", 1'b0, 4'b0000);
    end
    #1;
    rst_n = 1'b1;
    #1;
    check_all("release_hold", 1'b0, 4'b0000);
    push(1'b1, 4'b1010);
    @(posedge clk);
    #2;
    pop_check("post_release_capture");

    // Release coinciding with a rising edge: that edge is skipped.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    d1    = 1'b1;
    d4    = 4'b0110;
    #1;
    check_all("reset_again", 1'b0, 4'b0000);
    @(posedge clk);
    rst_n = 1'b1;
    #2;
    check_all("coincident_release", 1'b0, 4'b0000);
    push(1'b1, 4'b0110);
    @(posedge clk);
    #2;
    pop_check("after_coincident_release");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
